line_fetch_sequencer: RTL and testbench
=======================================

# line_fetch_sequencer

Draw-clock controller that sequences the per-scanline tile fetch and line-buffer fill pipeline. On each synchronized line pulse, it issues one beat per cycle to the tile BRAM / pixel doubler / shift aligner chain. Each beat carries tile coordinates, the line-buffer x address, the buffer select, and first/last markers. It replaces the free-running stage-d1 counters with a state machine that honours downstream backpressure, maintains the frame scroll counter and detects line overruns.

## Interface
Parameters:
- CORDW, 11, coordinate width of line_y
- LINE_BEATS, 64, fetch beats per line (32 tiles × 2 16-bit words); power of two, ≥2
- LB_STEP, 8, lb_x increment per beat (pixels written per beat)

Ports (clock: clk_draw; reset: rst_draw_n, asynchronous, active-low):
- clk_draw  in  1  draw clock
- rst_draw_n  in  1  asynchronous active-low reset
- line_start  in  1  single-cycle pulse, already synchronized to clk_draw
- frame_start  in  1  single-cycle pulse, already synchronized to clk_draw
- line_y  in  CORDW  line to prepare; sampled only on accepted line_start
- enable  in  1  permits new lines to start
- ready  in  1  downstream accepts current beat
- valid  out  1  beat present
- first  out  1  valid && beat index 0 (flushes doubler/aligner)
- last  out  1  valid && beat index LINE_BEATS-1
- tile_y  out  5  line_y[8:4]
- tile_row  out  3  line_y[3:1]
- tile_x  out  5  beat[5:1]
- tile_col  out  1  beat[0]
- lb_x  out  12  line-buffer x address of this beat
- bufsel  out  1  line_y[0]
- line_done  out  1  one-cycle pulse after the last beat is accepted
- busy  out  1  state == FETCH
- frame_counter  out  12  frame count, also the horizontal scroll base
- overrun_count  out  8  saturating count of aborted lines

## Operation
- States: IDLE, FETCH. Reset → IDLE, with all registers and outputs at 0.
- IDLE: valid=0. On line_start && enable: latch line_y, set beat=0, set lb_x=frame_counter (value before any same-cycle increment), go to FETCH.
- FETCH: valid=1. On ready: beat+1 and lb_x+LB_STEP (12-bit wrap). On !ready: every output holds stable.
- Last beat accepted (last && ready) with no line_start: go to IDLE and pulse line_done next cycle.
- line_start during FETCH before completion, with enable=1: abort the current line and restart at beat 0 with the new line_y and base. overrun_count increments, saturating at 255. No line_done is issued.
- line_start in the same cycle as last && ready: the line counts as complete. line_done pulses, there is no overrun, and the new line starts (FETCH, beat 0) with no idle cycle.
- line_start while enable=0: ignored, with no overrun. Dropping enable mid-line lets the current line finish.
- frame_start: frame_counter+1, wrapping at 4096. It is independent of the FSM and does not affect the lb_x of a line already in progress.
- Derived outputs (first, last, tile_*, bufsel) are decoded from registered beat/line_y state. They are only meaningful while valid=1.

## Timing
- Every output is registered; there are no combinational paths from any input to any output.
- Latency: line_start at edge n gives valid=1, first=1 after edge n.
- Throughput: one beat per cycle with ready held high. A full line then takes LINE_BEATS cycles of valid, and line_done appears one cycle after the last beat.
- A stall of k cycles extends the line by exactly k cycles.
- An abort takes effect on the next edge: the beat after line_start is beat 0 of the new line.
- Reset mid-line: valid, busy and line_done drop to 0 asynchronously. frame_counter and overrun_count clear.

## Test plan
- Basic line: line_y=0x025, frame_counter=0, ready=1. Expect 64 beats. Beat 0 has tile_y=2, tile_row=2, bufsel=1, tile_x=0, tile_col=0, lb_x=0, first=1. Beat 63 has tile_x=31, tile_col=1, lb_x=504, last=1. line_done follows one cycle after beat 63.
- Backpressure: ready low for 3 cycles at beat 10. Beat 10 outputs hold for 4 cycles, no beat is skipped or duplicated, and the line completes 3 cycles later than in the basic case.
- Scroll/wrap: 4095 frame_start pulses, then a line. lb_x starts at 4095, then goes 7, 15, and so on (12-bit wrap). One more frame_start sets frame_counter=0.
- Overrun: line_start at beat 20. Restart at beat 0 with the new line_y, overrun_count=1, and no line_done. After 300 overruns, overrun_count=255.
- Coincident events: line_start on the last && ready cycle. Expect line_done, overrun_count unchanged, and first=1 on the very next cycle. frame_start on the same cycle as line_start: that line uses the old frame_counter as its lb_x base.
- Enable/reset: enable=0 with line_start gives valid stays 0 and no overrun. Asserting rst_draw_n low at beat 30 clears all outputs immediately. After release the block sits in IDLE until the next line_start.

Source files
------------

// File: rtl/line_fetch_sequencer.sv
// Purpose: sequences one scanline of tile-fetch beats into the BRAM/doubler/aligner chain.
// Latency: line_start at edge n presents beat 0 (valid, first) after edge n; line_done 1 cycle after last beat.
// Backpressure: ready low freezes every output; beats are never skipped or repeated.
// Ports: clk_draw/rst_draw_n (async active-low); line_start, frame_start, line_y, enable, ready in;
//        valid, first, last, tile_y, tile_row, tile_x, tile_col, lb_x, bufsel, line_done, busy,
//        frame_counter, overrun_count out.
module line_fetch_sequencer #(
  parameter int CORDW      = 11,
  parameter int LINE_BEATS = 64,
  parameter int LB_STEP    = 8
) (
  input  logic             clk_draw,
  input  logic             rst_draw_n,
  input  logic             line_start,
  input  logic             frame_start,
  input  logic [CORDW-1:0] line_y,
  input  logic             enable,
  input  logic             ready,
  output logic             valid,
  output logic             first,
  output logic             last,
  output logic [4:0]       tile_y,
  output logic [2:0]       tile_row,
  output logic [4:0]       tile_x,
  output logic             tile_col,
  output logic [11:0]      lb_x,
  output logic             bufsel,
  output logic             line_done,
  output logic             busy,
  output logic [11:0]      frame_counter,
  output logic [7:0]       overrun_count
);

  localparam int BW = $clog2(LINE_BEATS);

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [8:0]    line_y_q, line_y_d;
  logic [11:0]   lb_x_q, lb_x_d;
  logic          line_done_q, line_done_d;
  logic [11:0]   frame_q, frame_d;
  logic [7:0]    overrun_q, overrun_d;

  logic          accept_start;
  logic          at_last;
  logic [5:0]    beat_ext;

  // Only line_y[8:0] selects tile row/bufsel; upper coordinate bits are unused here.
  logic          unused_line_y;
  assign unused_line_y = &{1'b0, line_y};

  assign accept_start = line_start && enable;
  assign at_last      = (beat_q == BW'(LINE_BEATS - 1));

  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      line_y_q    <= '0;
      lb_x_q      <= '0;
      line_done_q <= 1'b0;
      frame_q     <= '0;
      overrun_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      line_y_q    <= line_y_d;
      lb_x_q      <= lb_x_d;
      line_done_q <= line_done_d;
      frame_q     <= frame_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    line_y_d    = line_y_q;
    lb_x_d      = lb_x_q;
    line_done_d = 1'b0;
    overrun_d   = overrun_q;
    // Scroll base advances independently; a line in flight keeps its own lb_x.
    frame_d     = frame_q + {11'd0, frame_start};

    case (state_q)
      IDLE: begin
        if (accept_start) begin
          state_d  = FETCH;
          beat_d   = '0;
          line_y_d = line_y[8:0];
          lb_x_d   = frame_q;  // pre-increment value when frame_start coincides
        end
      end
      FETCH: begin
        if (accept_start) begin
          // A start landing on the accepted last beat completes the line;
          // anywhere else it aborts the line in progress.
          if (at_last && ready) begin
            line_done_d = 1'b1;
          end else if (overrun_q != 8'hFF) begin
            overrun_d = overrun_q + 8'd1;
          end
          beat_d   = '0;
          line_y_d = line_y[8:0];
          lb_x_d   = frame_q;
        end else if (ready) begin
          if (at_last) begin
            state_d     = IDLE;
            line_done_d = 1'b1;
          end else begin
            beat_d = beat_q + BW'(1);
            lb_x_d = lb_x_q + 12'(LB_STEP);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign beat_ext = 6'(beat_q);

  assign valid         = (state_q == FETCH);
  assign busy          = (state_q == FETCH);
  assign first         = valid && (beat_q == '0);
  assign last          = valid && at_last;
  assign tile_y        = line_y_q[8:4];
  assign tile_row      = line_y_q[3:1];
  assign bufsel        = line_y_q[0];
  assign tile_x        = beat_ext[5:1];
  assign tile_col      = beat_ext[0];
  assign lb_x          = lb_x_q;
  assign line_done     = line_done_q;
  assign frame_counter = frame_q;
  assign overrun_count = overrun_q;

endmodule

// File: tb/tb_line_fetch_sequencer.sv
module tb_line_fetch_sequencer;

  logic        clk_draw = 1'b0;
  logic        rst_draw_n;
  logic        line_start, frame_start, enable, ready;
  logic [10:0] line_y;
  logic        valid, first, last, tile_col, bufsel, line_done, busy;
  logic [4:0]  tile_y, tile_x;
  logic [2:0]  tile_row;
  logic [11:0] lb_x, frame_counter;
  logic [7:0]  overrun_count;

  line_fetch_sequencer #(.CORDW(11), .LINE_BEATS(64), .LB_STEP(8)) dut (
    .clk_draw(clk_draw), .rst_draw_n(rst_draw_n), .line_start(line_start),
    .frame_start(frame_start), .line_y(line_y), .enable(enable), .ready(ready),
    .valid(valid), .first(first), .last(last), .tile_y(tile_y), .tile_row(tile_row),
    .tile_x(tile_x), .tile_col(tile_col), .lb_x(lb_x), .bufsel(bufsel),
    .line_done(line_done), .busy(busy), .frame_counter(frame_counter),
    .overrun_count(overrun_count)
  );

  always #5 clk_draw = ~clk_draw;

  typedef struct packed {
    logic [4:0]  ty;
    logic [2:0]  tr;
    logic        bs;
    logic [4:0]  tx;
    logic        tc;
    logic [11:0] lbx;
    logic        f;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  int          tests = 0;
  int          fails = 0;
  bit          mon_en = 1'b1;
  logic [11:0] fc_exp = 12'd0;
  logic [7:0]  ov_exp = 8'd0;

  // Expected beats of a whole line, computed from line_y and the scroll base.
  function automatic void push_line(input logic [10:0] y, input logic [11:0] base);
    beat_t e;
    for (int i = 0; i < 64; i++) begin
      logic [5:0] b;
      b     = 6'(i);
      e.ty  = y[8:4];
      e.tr  = y[3:1];
      e.bs  = y[0];
      e.tx  = b[5:1];
      e.tc  = b[0];
      e.lbx = base + 12'(i * 8);
      e.f   = (i == 0);
      e.l   = (i == 63);
      exp_q.push_back(e);
    end
  endfunction

  // Scoreboard: every accepted beat is popped and compared.
  always @(negedge clk_draw) begin
    if (mon_en && valid && ready) begin
      beat_t e, a;
      a = '{tile_y, tile_row, bufsel, tile_x, tile_col, lb_x, first, last};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL beat_unexpected: got %h, no beat expected", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          fails++;
          $display("FAIL beat: got ty=%0d tr=%0d bs=%0d tx=%0d tc=%0d lbx=%0d f=%0d l=%0d, exp ty=%0d tr=%0d bs=%0d tx=%0d tc=%0d lbx=%0d f=%0d l=%0d",
                   a.ty, a.tr, a.bs, a.tx, a.tc, a.lbx, a.f, a.l, e.ty, e.tr, e.bs, e.tx, e.tc, e.lbx, e.f, e.l);
        end
      end
    end
  end

  task automatic test_reset;
    #12;
    tests++;
    if ({valid, busy, line_done, first, last, lb_x, frame_counter, overrun_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%0d busy=%0d done=%0d lb_x=%0d fc=%0d ov=%0d, exp all 0",
               valid, busy, line_done, lb_x, frame_counter, overrun_count);
    end
    @(posedge clk_draw); #1 rst_draw_n = 1'b1;
    @(negedge clk_draw);
    tests++;
    if (valid !== 1'b0) begin fails++; $display("FAIL reset_idle: valid=%0d exp 0", valid); end
  endtask

  task automatic test_basic;
    int done_c = -1;
    @(posedge clk_draw); #1;
    line_y = 11'h025; line_start = 1'b1; ready = 1'b1; enable = 1'b1;
    push_line(11'h025, fc_exp);
    @(posedge clk_draw); #1 line_start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk_draw);
      if (c == 1) begin
        tests++;
        if ({valid, first, busy} !== 3'b111) begin
          fails++; $display("FAIL basic_latency: valid/first/busy=%b exp 111", {valid, first, busy});
        end
      end
      if (line_done) begin done_c = c; break; end
    end
    tests++;
    if (done_c != 65) begin fails++; $display("FAIL basic_done_cycle: got %0d exp 65", done_c); end
    @(negedge clk_draw);
    tests++;
    if ({valid, line_done, 8'(exp_q.size())} !== 10'd0) begin
      fails++; $display("FAIL basic_end: valid=%0d done=%0d left=%0d exp 0 0 0", valid, line_done, exp_q.size());
    end
  endtask

  task automatic test_backpressure;
    int done_c = -1;
    @(posedge clk_draw); #1;
    line_y = 11'h1F0; line_start = 1'b1;
    push_line(11'h1F0, fc_exp);
    @(posedge clk_draw); #1 line_start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk_draw);
      if (c >= 11 && c <= 14) begin
        tests++;
        if ({valid, tile_x, tile_col, lb_x} !== {1'b1, 5'd5, 1'b0, fc_exp + 12'd80}) begin
          fails++; $display("FAIL bp_hold c=%0d: valid=%0d tx=%0d tc=%0d lb_x=%0d exp 1 5 0 %0d",
                            c, valid, tile_x, tile_col, lb_x, fc_exp + 12'd80);
        end
      end
      if (line_done) begin done_c = c; break; end
      @(posedge clk_draw); #1 ready = !(c >= 10 && c <= 12);
    end
    ready = 1'b1;
    tests++;
    if (done_c != 68) begin fails++; $display("FAIL bp_done_cycle: got %0d exp 68", done_c); end
  endtask

  task automatic test_scroll;
    int done_c = -1;
    @(posedge clk_draw); #1 frame_start = 1'b1;
    repeat (4095) @(posedge clk_draw);
    #1 frame_start = 1'b0;
    fc_exp = 12'd4095;
    tests++;
    if (frame_counter !== fc_exp) begin fails++; $display("FAIL scroll_fc: got %0d exp 4095", frame_counter); end
    line_y = 11'h3AA; line_start = 1'b1;
    push_line(11'h3AA, fc_exp);
    @(posedge clk_draw); #1 line_start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk_draw);
      if (line_done) begin done_c = c; break; end
    end
    tests++;
    if (done_c != 65) begin fails++; $display("FAIL scroll_done_cycle: got %0d exp 65", done_c); end
    @(posedge clk_draw); #1 frame_start = 1'b1;
    @(posedge clk_draw); #1 frame_start = 1'b0;
    fc_exp = 12'd0;
    tests++;
    if (frame_counter !== fc_exp) begin fails++; $display("FAIL scroll_wrap: got %0d exp 0", frame_counter); end
  endtask

  task automatic test_overrun;
    int done_c = -1;
    @(posedge clk_draw); #1;
    line_y = 11'h100; line_start = 1'b1;
    push_line(11'h100, fc_exp);
    @(posedge clk_draw); #1 line_start = 1'b0;
    repeat (20) @(posedge clk_draw);
    #1 line_y = 11'h0A3; line_start = 1'b1;
    @(posedge clk_draw); #1 line_start = 1'b0;
    exp_q.delete();
    push_line(11'h0A3, fc_exp);
    ov_exp = 8'd1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk_draw);
      if (c == 1) begin
        tests++;
        if ({first, overrun_count, line_done} !== {1'b1, ov_exp, 1'b0}) begin
          fails++; $display("FAIL overrun_restart: first=%0d ov=%0d done=%0d exp 1 %0d 0",
                            first, overrun_count, line_done, ov_exp);
        end
      end
      if (line_done) begin done_c = c; break; end
    end
    tests++;
    if (done_c != 65) begin fails++; $display("FAIL overrun_done_cycle: got %0d exp 65", done_c); end
    // Flood: first edge starts from idle, the next 299 abort -> 300 overruns in total.
    mon_en = 1'b0;
    @(posedge clk_draw); #1 line_start = 1'b1;
    repeat (300) @(posedge clk_draw);
    #1 line_start = 1'b0;
    ov_exp = 8'd255;
    tests++;
    if (overrun_count !== ov_exp) begin fails++; $display("FAIL overrun_saturate: got %0d exp 255", overrun_count); end
    done_c = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk_draw);
      if (line_done) begin done_c = c; break; end
    end
    tests++;
    if (done_c < 0) begin fails++; $display("FAIL overrun_flood_finish: no line_done within 200 cycles"); end
    @(posedge clk_draw); #1;
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  task automatic test_coincident;
    int done_c = -1;
    @(posedge clk_draw); #1;
    line_y = 11'h011; line_start = 1'b1;
    push_line(11'h011, fc_exp);
    @(posedge clk_draw); #1 line_start = 1'b0;
    repeat (63) @(posedge clk_draw);
    #1 line_y = 11'h022; line_start = 1'b1; frame_start = 1'b1;
    push_line(11'h022, fc_exp);  // new line takes the pre-increment base
    @(posedge clk_draw); #1 line_start = 1'b0; frame_start = 1'b0;
    fc_exp = fc_exp + 12'd1;
    @(negedge clk_draw);
    tests++;
    if ({line_done, first, valid, overrun_count, frame_counter} !== {3'b111, ov_exp, fc_exp}) begin
      fails++; $display("FAIL coincident: done=%0d first=%0d valid=%0d ov=%0d fc=%0d exp 1 1 1 %0d %0d",
                        line_done, first, valid, overrun_count, frame_counter, ov_exp, fc_exp);
    end
    for (int c = 2; c <= 200; c++) begin
      @(negedge clk_draw);
      if (line_done) begin done_c = c; break; end
    end
    tests++;
    if (done_c != 65) begin fails++; $display("FAIL coincident_done_cycle: got %0d exp 65", done_c); end
  endtask

  task automatic test_enable_reset;
    int done_c = -1;
    @(posedge clk_draw); #1 enable = 1'b0; line_start = 1'b1; line_y = 11'h055;
    @(posedge clk_draw); #1 line_start = 1'b0;
    @(negedge clk_draw);
    tests++;
    if ({valid, overrun_count} !== {1'b0, ov_exp}) begin
      fails++; $display("FAIL enable_ignored: valid=%0d ov=%0d exp 0 %0d", valid, overrun_count, ov_exp);
    end
    // Mid-line enable drop with a stray line_start: line finishes untouched.
    @(posedge clk_draw); #1 enable = 1'b1; line_start = 1'b1; line_y = 11'h077;
    push_line(11'h077, fc_exp);
    @(posedge clk_draw); #1 line_start = 1'b0;
    repeat (5) @(posedge clk_draw);
    #1 enable = 1'b0; line_start = 1'b1; line_y = 11'h0EE;
    @(posedge clk_draw); #1 line_start = 1'b0;
    for (int c = 7; c <= 200; c++) begin
      @(negedge clk_draw);
      if (line_done) begin done_c = c; break; end
    end
    tests++;
    if ({done_c, overrun_count} !== {32'd65, ov_exp}) begin
      fails++; $display("FAIL enable_drop: done at %0d ov=%0d exp 65 %0d", done_c, overrun_count, ov_exp);
    end
    // Asynchronous reset in the middle of a line.
    @(posedge clk_draw); #1 enable = 1'b1; line_start = 1'b1; line_y = 11'h123;
    push_line(11'h123, fc_exp);
    @(posedge clk_draw); #1 line_start = 1'b0;
    repeat (30) @(posedge clk_draw);
    #2 rst_draw_n = 1'b0;
    #1;
    tests++;
    if ({valid, busy, line_done, first, frame_counter, overrun_count} !== '0) begin
      fails++; $display("FAIL reset_midline: valid=%0d busy=%0d done=%0d fc=%0d ov=%0d exp all 0",
                        valid, busy, line_done, frame_counter, overrun_count);
    end
    exp_q.delete();
    fc_exp = 12'd0; ov_exp = 8'd0;
    #3 rst_draw_n = 1'b1;
    repeat (3) @(negedge clk_draw);
    tests++;
    if ({valid, busy} !== 2'b00) begin fails++; $display("FAIL reset_release_idle: valid=%0d busy=%0d exp 0 0", valid, busy); end
    @(posedge clk_draw); #1 line_start = 1'b1; line_y = 11'h002;
    push_line(11'h002, fc_exp);
    @(posedge clk_draw); #1 line_start = 1'b0;
    done_c = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk_draw);
      if (line_done) begin done_c = c; break; end
    end
    tests++;
    if (done_c != 65) begin fails++; $display("FAIL post_reset_line: done at %0d exp 65", done_c); end
  endtask

  initial begin
    rst_draw_n = 1'b0; line_start = 1'b0; frame_start = 1'b0;
    enable = 1'b0; ready = 1'b1; line_y = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_scroll();
    test_overrun();
    test_coincident();
    test_enable_reset();
    @(negedge clk_draw);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL leftover_beats: got %0d exp 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
